// File: rtl/da_sample_scheduler.sv
// Sample sequencer for the distributed-arithmetic FIR datapath: owns the 64-tap delay line,
// walks the 16 bit-slices of each sample through da, and arbitrates coefficient-ROM writes.
module da_sample_scheduler #(
   parameter int SAMPLE_W = 16,
   parameter int ACC_W    = 38,
   parameter int TIMEOUT  = 255
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [SAMPLE_W-1:0] in_data,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic [10:0]         cfg_addr,
   input  logic [18:0]         cfg_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [ACC_W-1:0]    out_data,
   output logic [63:0]         da_addr,
   output logic                da_start,
   output logic                da_clear,
   output logic                da_resetn,
   output logic                da_cload,
   output logic [10:0]         da_caddr,
   output logic [18:0]         da_cin,
   input  logic                da_done,
   input  logic [ACC_W-1:0]    da_acc,
   output logic                busy,
   output logic                err
);

   localparam int TAPS  = 64;
   localparam int BIT_W = $clog2(SAMPLE_W);
   localparam logic [7:0]       TMO_LAST = 8'(TIMEOUT - 1);
   localparam logic [BIT_W-1:0] MSB_BIT  = BIT_W'(SAMPLE_W - 1);

   typedef enum logic [2:0] {IDLE, CFG, CLEAR, ISSUE, WAIT, SETTLE, OUT} state_t;

   state_t              state_reg;
   logic [SAMPLE_W-1:0] tap_reg [TAPS];
   logic [BIT_W-1:0]    bit_reg;
   logic [BIT_W-1:0]    load_bit;
   logic [7:0]          tmo_reg;
   logic                settle_reg;
   logic                ready_reg;
   logic [1:0]          rstn_sync_reg;
   logic [TAPS-1:0]     slice_bits;
   logic                cfg_fire;
   logic                in_fire;

   logic                out_valid_reg;
   logic [ACC_W-1:0]    out_data_reg;
   logic [63:0]         da_addr_reg;
   logic                da_start_reg;
   logic                da_clear_reg;
   logic                da_cload_reg;
   logic [10:0]         da_caddr_reg;
   logic [18:0]         da_cin_reg;
   logic                busy_reg;
   logic                err_reg;

   // Config wins a same-cycle tie, so the sample side is masked by cfg_valid.
   assign cfg_fire  = cfg_valid & ready_reg;
   assign in_fire   = in_valid & ready_reg & ~cfg_valid;
   assign cfg_ready = ready_reg;
   assign in_ready  = ready_reg & ~cfg_valid;

   assign out_valid = out_valid_reg;
   assign out_data  = out_data_reg;
   assign da_addr   = da_addr_reg;
   assign da_start  = da_start_reg;
   assign da_clear  = da_clear_reg;
   assign da_cload  = da_cload_reg;
   assign da_caddr  = da_caddr_reg;
   assign da_cin    = da_cin_reg;
   assign busy      = busy_reg;
   assign err       = err_reg;
   assign da_resetn = rstn_sync_reg[1];

   // SETTLE loads the next (lower) slice; CLEAR loads the sign slice already in bit_reg.
   assign load_bit = (state_reg == SETTLE) ? bit_reg - 1'b1 : bit_reg;

   genvar gi;
   generate
      for (gi = 0; gi < TAPS; gi++) begin : g_slice
         assign slice_bits[gi] = tap_reg[gi][load_bit];
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rstn_sync_reg <= 2'b00;
      end else begin
         rstn_sync_reg <= {rstn_sync_reg[0], 1'b1};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < TAPS; i++) tap_reg[i] <= '0;
      end else if (in_fire) begin
         tap_reg[0] <= in_data;
         for (int i = 1; i < TAPS; i++) tap_reg[i] <= tap_reg[i-1];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= IDLE;
         bit_reg       <= '0;
         tmo_reg       <= '0;
         settle_reg    <= 1'b0;
         ready_reg     <= 1'b0;
         out_valid_reg <= 1'b0;
         out_data_reg  <= '0;
         da_addr_reg   <= '0;
         da_start_reg  <= 1'b0;
         da_clear_reg  <= 1'b0;
         da_cload_reg  <= 1'b0;
         da_caddr_reg  <= '0;
         da_cin_reg    <= '0;
         busy_reg      <= 1'b0;
         err_reg       <= 1'b0;
      end else begin
         da_start_reg <= 1'b0;
         da_clear_reg <= 1'b0;
         da_cload_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (cfg_fire) begin
                  da_cload_reg <= 1'b1;
                  da_caddr_reg <= cfg_addr;
                  da_cin_reg   <= cfg_data;
                  ready_reg    <= 1'b0;
                  busy_reg     <= 1'b1;
                  state_reg    <= CFG;
               end else if (in_fire) begin
                  bit_reg      <= MSB_BIT;
                  da_clear_reg <= 1'b1;
                  ready_reg    <= 1'b0;
                  busy_reg     <= 1'b1;
                  state_reg    <= CLEAR;
               end else begin
                  ready_reg <= 1'b1;
               end
            end
            CFG: begin
               ready_reg <= 1'b1;
               busy_reg  <= 1'b0;
               state_reg <= IDLE;
            end
            CLEAR: begin
               da_addr_reg  <= slice_bits;
               da_start_reg <= 1'b1;
               state_reg    <= ISSUE;
            end
            ISSUE: begin
               tmo_reg   <= '0;
               state_reg <= WAIT;
            end
            WAIT: begin
               if (da_done) begin
                  settle_reg <= 1'b0;
                  state_reg  <= SETTLE;
               end else if (tmo_reg == TMO_LAST) begin
                  tmo_reg   <= tmo_reg + 1'b1;
                  err_reg   <= 1'b1;
                  busy_reg  <= 1'b0;
                  ready_reg <= 1'b1;
                  state_reg <= IDLE;
               end else begin
                  tmo_reg <= tmo_reg + 1'b1;
               end
            end
            SETTLE: begin
               // Two cycles here let da fold the slice into ACC before it is sampled.
               if (!settle_reg) begin
                  settle_reg <= 1'b1;
               end else if (bit_reg != '0) begin
                  bit_reg      <= bit_reg - 1'b1;
                  da_addr_reg  <= slice_bits;
                  da_start_reg <= 1'b1;
                  state_reg    <= ISSUE;
               end else begin
                  out_data_reg  <= da_acc;
                  out_valid_reg <= 1'b1;
                  state_reg     <= OUT;
               end
            end
            OUT: begin
               if (out_ready) begin
                  out_valid_reg <= 1'b0;
                  busy_reg      <= 1'b0;
                  ready_reg     <= 1'b1;
                  state_reg     <= IDLE;
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_da_sample_scheduler.sv
// Directed bench for da_sample_scheduler with a da stub that answers one cycle after each start
// and an accumulator that counts clock edges, so capture timing shows up in out_data.
module tb_da_sample_scheduler;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_data = '0;
   logic        cfg_valid = 1'b0;
   logic        cfg_ready;
   logic [10:0] cfg_addr = '0;
   logic [18:0] cfg_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [37:0] out_data;
   logic [63:0] da_addr;
   logic        da_start;
   logic        da_clear;
   logic        da_resetn;
   logic        da_cload;
   logic [10:0] da_caddr;
   logic [18:0] da_cin;
   logic        da_done = 1'b0;
   logic [37:0] da_acc;
   logic        busy;
   logic        err;

   int          checks = 0;
   int          errors = 0;
   logic        done_en = 1'b1;
   logic [37:0] acc_cnt = '0;
   logic [63:0] slice_addr [16];

   da_sample_scheduler #(.SAMPLE_W(16), .ACC_W(38), .TIMEOUT(255)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .da_addr(da_addr), .da_start(da_start), .da_clear(da_clear), .da_resetn(da_resetn),
      .da_cload(da_cload), .da_caddr(da_caddr), .da_cin(da_cin),
      .da_done(da_done), .da_acc(da_acc), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      da_done <= da_start & done_en;
      acc_cnt <= acc_cnt + 38'd1;
   end
   assign da_acc = acc_cnt;

   // Offers one sample; returns at the negedge right after the accept edge (DUT in CLEAR).
   task automatic offer_sample(input logic [15:0] d, output logic [37:0] acc0);
      logic ok;
      ok = 1'b0;
      acc0 = '0;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      for (int i = 0; i < 300; i++) begin
         #1;
         if (in_ready) begin
            acc0 = acc_cnt;
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      if (!ok) begin
         checks++; errors++;
         $display("FAIL accept: in_ready never rose for sample %h", d);
      end
   endtask

   // Edge count starts at 1 on the accept edge; stops at the first cycle out_valid is seen.
   task automatic run_to_output(output int edges, output int starts, output logic got);
      edges = 1; starts = 0; got = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (da_start) begin
            if (starts < 16) slice_addr[starts] = da_addr;
            starts++;
         end
         if (out_valid) begin
            got = 1'b1;
            break;
         end
         @(negedge clk);
         edges++;
      end
   endtask

   task automatic finish_output();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if ({out_valid, in_ready, cfg_ready, da_start, da_clear, da_cload, da_resetn, busy, err} !== 9'b0) begin
         errors++;
         $display("FAIL reset_flags: got %b expected 000000000",
                  {out_valid, in_ready, cfg_ready, da_start, da_clear, da_cload, da_resetn, busy, err});
      end
      checks++;
      if (out_data !== 38'd0 || da_addr !== 64'd0) begin
         errors++; $display("FAIL reset_data: out_data %h da_addr %h expected 0", out_data, da_addr);
      end
      checks++;
      if (da_caddr !== 11'd0 || da_cin !== 19'd0) begin
         errors++; $display("FAIL reset_caddr: caddr %h cin %h expected 0", da_caddr, da_cin);
      end
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (da_resetn !== 1'b0) begin
         errors++; $display("FAIL resetn_edge1: got %b expected 0", da_resetn);
      end
      @(negedge clk);
      checks++;
      if (da_resetn !== 1'b1) begin
         errors++; $display("FAIL resetn_edge2: got %b expected 1", da_resetn);
      end
      checks++;
      if (cfg_ready !== 1'b1 || in_ready !== 1'b1) begin
         errors++; $display("FAIL idle_ready: cfg_ready %b in_ready %b expected 1 1", cfg_ready, in_ready);
      end
   endtask

   task automatic test_config();
      @(negedge clk);
      cfg_valid = 1'b1; in_valid = 1'b1; in_data = 16'hBEEF;
      cfg_addr = 11'h105; cfg_data = 19'h12345;
      #1;
      checks++;
      if (in_ready !== 1'b0 || cfg_ready !== 1'b1) begin
         errors++; $display("FAIL cfg_priority: in_ready %b cfg_ready %b expected 0 1", in_ready, cfg_ready);
      end
      @(negedge clk);
      cfg_valid = 1'b0; in_valid = 1'b0;
      checks++;
      if (da_cload !== 1'b1 || da_caddr !== 11'h105 || da_cin !== 19'h12345) begin
         errors++; $display("FAIL cload_write: cload %b caddr %h cin %h expected 1 105 12345", da_cload, da_caddr, da_cin);
      end
      checks++;
      if (cfg_ready !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin
         errors++; $display("FAIL cfg_busy: cfg_ready %b in_ready %b busy %b expected 0 0 1", cfg_ready, in_ready, busy);
      end
      @(negedge clk);
      checks++;
      if (da_cload !== 1'b0 || cfg_ready !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL cfg_return: cload %b cfg_ready %b busy %b expected 0 1 0", da_cload, cfg_ready, busy);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || da_clear !== 1'b0) begin
         errors++; $display("FAIL cfg_no_sample: busy %b clear %b expected 0 0", busy, da_clear);
      end
   endtask

   task automatic test_single_sample();
      logic [37:0] acc0;
      int edges, starts;
      logic got;
      logic [63:0] exp_addr;
      offer_sample(16'h8001, acc0);
      checks++;
      if (da_clear !== 1'b1) begin
         errors++; $display("FAIL clear_pulse: got %b expected 1", da_clear);
      end
      run_to_output(edges, starts, got);
      checks++;
      if (!got || edges != 66) begin
         errors++; $display("FAIL latency: got %0d edges (out_valid %b) expected 66", edges, got);
      end
      checks++;
      if (starts != 16) begin
         errors++; $display("FAIL start_count: got %0d expected 16", starts);
      end
      for (int k = 0; k < 16; k++) begin
         exp_addr = (k == 0 || k == 15) ? 64'h1 : 64'h0;
         checks++;
         if (slice_addr[k] !== exp_addr) begin
            errors++; $display("FAIL slice_addr b=%0d: got %h expected %h", 15 - k, slice_addr[k], exp_addr);
         end
      end
      checks++;
      if (out_data !== acc0 + 38'd65) begin
         errors++; $display("FAIL out_capture: got %h expected %h", out_data, acc0 + 38'd65);
      end
      finish_output();
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL out_release: out_valid %b busy %b expected 0 0", out_valid, busy);
      end
   endtask

   task automatic test_backpressure();
      logic [37:0] acc0, acc1;
      int edges, starts;
      logic got;
      offer_sample(16'h1234, acc0);
      run_to_output(edges, starts, got);
      checks++;
      if (!got) begin
         errors++; $display("FAIL bp_output: out_valid %b expected 1", out_valid);
      end
      in_valid = 1'b1; in_data = 16'h0055;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || out_data !== acc0 + 38'd65 || in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_hold cycle %0d: out_valid %b out_data %h in_ready %b expected 1 %h 0",
                               c, out_valid, out_data, in_ready, acc0 + 38'd65);
         end
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      acc1 = acc_cnt;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL bp_release: out_valid %b busy %b in_ready %b expected 0 0 1", out_valid, busy, in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (busy !== 1'b1 || in_ready !== 1'b0) begin
         errors++; $display("FAIL bp_accept: busy %b in_ready %b expected 1 0", busy, in_ready);
      end
      run_to_output(edges, starts, got);
      checks++;
      if (!got || edges != 66 || out_data !== acc1 + 38'd65) begin
         errors++; $display("FAIL bp_second: edges %0d out_data %h expected 66 %h", edges, out_data, acc1 + 38'd65);
      end
      finish_output();
   endtask

   task automatic test_wrap();
      logic [37:0] acc0;
      int edges, starts, missed;
      logic got;
      do_reset();
      missed = 0;
      for (int n = 1; n <= 65; n++) begin
         offer_sample(16'(n), acc0);
         run_to_output(edges, starts, got);
         if (!got) missed++;
         if (n < 65) finish_output();
      end
      checks++;
      if (missed != 0) begin
         errors++; $display("FAIL wrap_outputs: got %0d missing results expected 0", missed);
      end
      checks++;
      if (slice_addr[14][63] !== 1'b1 || slice_addr[14] !== 64'hCCCC_CCCC_CCCC_CCCC) begin
         errors++; $display("FAIL wrap_b1: got %h expected cccccccccccccccc", slice_addr[14]);
      end
      checks++;
      if (slice_addr[15][63] !== 1'b0 || slice_addr[15] !== 64'h5555_5555_5555_5555) begin
         errors++; $display("FAIL wrap_b0: got %h expected 5555555555555555", slice_addr[15]);
      end
      finish_output();
   endtask

   task automatic test_timeout();
      logic [37:0] acc0;
      int edges, starts, n;
      logic got, seen, bad;
      checks++;
      if (err !== 1'b0) begin
         errors++; $display("FAIL err_clear: got %b expected 0", err);
      end
      done_en = 1'b0;
      offer_sample(16'h7FFF, acc0);
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         if (da_start) seen = 1'b1;
         else @(negedge clk);
      end
      n = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         n++;
         if (err) break;
      end
      checks++;
      if (!seen || n != 256) begin
         errors++; $display("FAIL timeout_edges: got %0d (start seen %b) expected 256", n, seen);
      end
      checks++;
      if (err !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL timeout_idle: err %b busy %b out_valid %b in_ready %b expected 1 0 0 1",
                            err, busy, out_valid, in_ready);
      end
      bad = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (out_valid) bad = 1'b1;
      end
      checks++;
      if (bad) begin
         errors++; $display("FAIL timeout_no_out: out_valid seen 1 expected 0");
      end
      done_en = 1'b1;
      offer_sample(16'h0003, acc0);
      run_to_output(edges, starts, got);
      checks++;
      if (!got || edges != 66 || out_data !== acc0 + 38'd65) begin
         errors++; $display("FAIL after_timeout: edges %0d out_data %h expected 66 %h", edges, out_data, acc0 + 38'd65);
      end
      checks++;
      if (err !== 1'b1) begin
         errors++; $display("FAIL err_sticky: got %b expected 1", err);
      end
      finish_output();
   endtask

   task automatic test_reset_mid_wait();
      logic [37:0] acc0;
      logic bad;
      done_en = 1'b0;
      offer_sample(16'h4000, acc0);
      repeat (6) @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if ({out_valid, in_ready, cfg_ready, da_start, da_clear, da_cload, da_resetn, busy, err} !== 9'b0) begin
         errors++;
         $display("FAIL midreset_flags: got %b expected 000000000",
                  {out_valid, in_ready, cfg_ready, da_start, da_clear, da_cload, da_resetn, busy, err});
      end
      checks++;
      if (da_addr !== 64'd0 || out_data !== 38'd0) begin
         errors++; $display("FAIL midreset_data: da_addr %h out_data %h expected 0", da_addr, out_data);
      end
      done_en = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (da_resetn !== 1'b0) begin
         errors++; $display("FAIL midreset_resetn1: got %b expected 0", da_resetn);
      end
      @(negedge clk);
      checks++;
      if (da_resetn !== 1'b1) begin
         errors++; $display("FAIL midreset_resetn2: got %b expected 1", da_resetn);
      end
      bad = 1'b0;
      repeat (100) begin
         @(negedge clk);
         if (out_valid || busy) bad = 1'b1;
      end
      checks++;
      if (bad) begin
         errors++; $display("FAIL midreset_abandon: out_valid or busy seen 1 expected 0");
      end
   endtask

   initial begin
      test_reset();
      test_config();
      test_single_sample();
      test_backpressure();
      test_wrap();
      test_timeout();
      test_reset_mid_wait();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
